sha256_msg_feeder: RTL and testbench

Upstream stage of the SHA256 message expansion block. It accepts a big-endian 32-bit word stream, applies SHA256 padding (0x80 byte, zero fill, 64-bit bit length) and buffers each 512-bit block. It then streams 64 rounds per block: words W0..W15 with sel=0, followed by 48 cycles with sel=1. Its outputs drive the expansion block's `in` and `sel` directly and mark rounds for the compression core.

---
 rtl/sha256_msg_feeder.sv | 227 ++++++++++++++++++++++
 tb/tb_sha256_msg_feeder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_feeder.sv
// rtl/sha256_msg_feeder.sv - SHA256 message padder, block buffer and 64-round word streamer
//
// Purpose: accepts a big-endian 32-bit word stream, applies SHA256 padding
// (0x80 byte, zero fill, 64-bit bit length), buffers each 512-bit block and
// streams 64 rounds per block to the message expansion stage.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_data/in_valid/in_last message word stream, in_bytes = valid bytes of last word (0 means 4)
//   in_ready                 a word is accepted this cycle when in_valid is also high
//   core_ready               compression core may start a block
//   out_word/out_sel         expansion stage `in` / `sel`
//   out_valid/out_round      round active / round index t
//   out_first                high at t=0
//   out_last_block           high for all rounds of the message's final block
//   msg_done                 one-cycle pulse after round 63 of the final block
module sha256_msg_feeder #(
    parameter int LEN_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic [1:0]  in_bytes,
    output logic        in_ready,
    input  logic        core_ready,
    output logic [31:0] out_word,
    output logic        out_sel,
    output logic        out_valid,
    output logic [5:0]  out_round,
    output logic        out_first,
    output logic        out_last_block,
    output logic        msg_done
);

    typedef enum logic [1:0] {S_FILL, S_PAD, S_WAIT, S_EMIT} state_t;

    state_t             state_q, state_d;
    logic [3:0]         wi_q, wi_d;
    logic [4:0]         pad_idx_q, pad_idx_d;   // next buffer index to write in PAD; 16 = block full
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               need80_q, need80_d;     // 0x80000000 still owed at pad_idx
    logic               lenfit_q, lenfit_d;     // this block receives the length field
    logic               ovf_q, ovf_d;           // an extra padding block follows
    logic               final_q, final_d;
    logic [5:0]         t_q, t_d;
    logic [31:0]        mbuf_q [16];
    logic [31:0]        mbuf_d [16];

    logic               in_ready_q, in_ready_d;
    logic [31:0]        out_word_q, out_word_d;
    logic               out_sel_q, out_sel_d;
    logic               out_valid_q, out_valid_d;
    logic [5:0]         out_round_q, out_round_d;
    logic               out_first_q, out_first_d;
    logic               out_last_block_q, out_last_block_d;
    logic               msg_done_q, msg_done_d;

    logic [2:0]         nbytes;
    logic [3:0]         pidx;
    logic [63:0]        len64;

    // Bit length; shifting the 64-bit value drops any bits beyond the field.
    assign len64 = 64'(cnt_q) << 3;

    always_comb begin
        state_d    = state_q;
        wi_d       = wi_q;
        pad_idx_d  = pad_idx_q;
        cnt_d      = cnt_q;
        need80_d   = need80_q;
        lenfit_d   = lenfit_q;
        ovf_d      = ovf_q;
        final_d    = final_q;
        t_d        = t_q;
        mbuf_d     = mbuf_q;
        msg_done_d = 1'b0;
        nbytes     = 3'd4;
        pidx       = pad_idx_q[3:0];

        case (state_q)
            S_FILL: begin
                if (in_valid && in_ready_q) begin
                    nbytes = (in_last && in_bytes != 2'd0) ? {1'b0, in_bytes} : 3'd4;
                    cnt_d  = cnt_q + LEN_W'(nbytes);
                    if (!in_last) begin
                        mbuf_d[wi_q] = in_data;
                        if (wi_q == 4'd15) begin
                            state_d = S_WAIT;
                            final_d = 1'b0;
                        end else begin
                            wi_d = wi_q + 4'd1;
                        end
                    end else begin
                        // Partial last word carries its own 0x80 byte; a full
                        // one leaves 0x80000000 owed at the next index.
                        case (in_bytes)
                            2'd1:    mbuf_d[wi_q] = {in_data[31:24], 8'h80, 16'h0000};
                            2'd2:    mbuf_d[wi_q] = {in_data[31:16], 8'h80, 8'h00};
                            2'd3:    mbuf_d[wi_q] = {in_data[31:8], 8'h80};
                            default: mbuf_d[wi_q] = in_data;
                        endcase
                        pad_idx_d = {1'b0, wi_q} + 5'd1;
                        need80_d  = (in_bytes == 2'd0);
                        lenfit_d  = (in_bytes == 2'd0) ? (wi_q <= 4'd12) : (wi_q <= 4'd13);
                        state_d   = S_PAD;
                    end
                end
            end
            S_PAD: begin
                if (pad_idx_q[4]) begin
                    // Data filled the block; 0x80 (if still owed) moves to the next one.
                    ovf_d   = 1'b1;
                    final_d = 1'b0;
                    state_d = S_WAIT;
                end else begin
                    if (need80_q)
                        mbuf_d[pidx] = 32'h8000_0000;
                    else if (lenfit_q && pidx == 4'd14)
                        mbuf_d[pidx] = len64[63:32];
                    else if (lenfit_q && pidx == 4'd15)
                        mbuf_d[pidx] = len64[31:0];
                    else
                        mbuf_d[pidx] = 32'h0;
                    need80_d  = 1'b0;
                    pad_idx_d = pad_idx_q + 5'd1;
                    if (pidx == 4'd15) begin
                        state_d = S_WAIT;
                        final_d = lenfit_q;
                        ovf_d   = !lenfit_q;
                    end
                end
            end
            S_WAIT: begin
                if (core_ready) begin
                    state_d = S_EMIT;
                    t_d     = 6'd0;
                end
            end
            S_EMIT: begin
                if (t_q == 6'd63) begin
                    wi_d = 4'd0;
                    if (ovf_q) begin
                        state_d   = S_PAD;
                        pad_idx_d = 5'd0;
                        lenfit_d  = 1'b1;
                        ovf_d     = 1'b0;
                    end else if (final_q) begin
                        msg_done_d = 1'b1;
                        cnt_d      = '0;
                        final_d    = 1'b0;
                        need80_d   = 1'b0;
                        lenfit_d   = 1'b0;
                        state_d    = S_FILL;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    t_d = t_q + 6'd1;
                end
            end
            default: state_d = S_FILL;
        endcase

        // Outputs are registered from the next state so they line up with it.
        in_ready_d       = (state_d == S_FILL);
        out_valid_d      = (state_d == S_EMIT);
        out_round_d      = (state_d == S_EMIT) ? t_d : 6'd0;
        out_first_d      = (state_d == S_EMIT) && (t_d == 6'd0);
        out_sel_d        = (state_d == S_EMIT) && (t_d[5:4] != 2'b00);
        out_word_d       = ((state_d == S_EMIT) && (t_d[5:4] == 2'b00)) ? mbuf_q[t_d[3:0]] : 32'h0;
        out_last_block_d = (state_d == S_EMIT) && final_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_FILL;
            wi_q             <= 4'd0;
            pad_idx_q        <= 5'd0;
            cnt_q            <= '0;
            need80_q         <= 1'b0;
            lenfit_q         <= 1'b0;
            ovf_q            <= 1'b0;
            final_q          <= 1'b0;
            t_q              <= 6'd0;
            for (int i = 0; i < 16; i++) mbuf_q[i] <= 32'h0;
            in_ready_q       <= 1'b0;
            out_word_q       <= 32'h0;
            out_sel_q        <= 1'b0;
            out_valid_q      <= 1'b0;
            out_round_q      <= 6'd0;
            out_first_q      <= 1'b0;
            out_last_block_q <= 1'b0;
            msg_done_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            wi_q             <= wi_d;
            pad_idx_q        <= pad_idx_d;
            cnt_q            <= cnt_d;
            need80_q         <= need80_d;
            lenfit_q         <= lenfit_d;
            ovf_q            <= ovf_d;
            final_q          <= final_d;
            t_q              <= t_d;
            mbuf_q           <= mbuf_d;
            in_ready_q       <= in_ready_d;
            out_word_q       <= out_word_d;
            out_sel_q        <= out_sel_d;
            out_valid_q      <= out_valid_d;
            out_round_q      <= out_round_d;
            out_first_q      <= out_first_d;
            out_last_block_q <= out_last_block_d;
            msg_done_q       <= msg_done_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_word       = out_word_q;
    assign out_sel        = out_sel_q;
    assign out_valid      = out_valid_q;
    assign out_round      = out_round_q;
    assign out_first      = out_first_q;
    assign out_last_block = out_last_block_q;
    assign msg_done       = msg_done_q;

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// tb/tb_sha256_msg_feeder.sv - scoreboard bench for sha256_msg_feeder
module tb_sha256_msg_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic [1:0]  in_bytes;
    logic        in_ready;
    logic        core_ready;
    logic [31:0] out_word;
    logic        out_sel;
    logic        out_valid;
    logic [5:0]  out_round;
    logic        out_first;
    logic        out_last_block;
    logic        msg_done;

    sha256_msg_feeder #(.LEN_W(64)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_bytes(in_bytes),
        .in_ready(in_ready), .core_ready(core_ready),
        .out_word(out_word), .out_sel(out_sel), .out_valid(out_valid), .out_round(out_round),
        .out_first(out_first), .out_last_block(out_last_block), .msg_done(msg_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic        sel;
        logic [5:0]  round;
        logic        last;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [7:0] msg[$];
    int         errors = 0;
    int         checks = 0;
    bit         done_pending = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference padding built byte-wise, then sliced into rounds.
    task automatic push_expected();
        logic [7:0]  pb[$];
        logic [63:0] len;
        int          nb;
        exp_t        x;
        pb = msg;
        pb.push_back(8'h80);
        while (pb.size() % 64 != 56) pb.push_back(8'h00);
        len = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) pb.push_back(len[i*8 +: 8]);
        nb = pb.size() / 64;
        for (int b = 0; b < nb; b++) begin
            for (int t = 0; t < 64; t++) begin
                x.round = 6'(t);
                x.sel   = (t >= 16);
                x.last  = (b == nb - 1);
                x.word  = (t < 16) ? {pb[b*64+4*t], pb[b*64+4*t+1], pb[b*64+4*t+2], pb[b*64+4*t+3]} : 32'h0;
                sb.push_back(x);
            end
        end
    endtask

    task automatic make_msg(input int n, input bit abc);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(abc ? 8'(8'h61 + i) : 8'($urandom_range(0, 255)));
    endtask

    // Called at a negedge; returns at a negedge after the last word is accepted.
    task automatic send_msg();
        int          n;
        int          nw;
        int          k;
        int          c;
        logic [31:0] d;
        n  = msg.size();
        nw = (n + 3) / 4;
        push_expected();
        for (int w = 0; w < nw; w++) begin
            k = (w == nw - 1) ? n - 4 * w : 4;
            d = 32'h0;
            for (int j = 0; j < 4; j++) d = {d[23:0], (j < k) ? msg[4*w+j] : 8'h99};
            in_valid = 1'b1;
            in_data  = d;
            in_last  = (w == nw - 1);
            in_bytes = (k == 4) ? 2'd0 : 2'(k);
            c = 0;
            while (!in_ready && c < 2000) begin
                @(negedge clk);
                c++;
            end
            if (c >= 2000) check_val("in_ready_timeout", 32'd0, 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (sb.size() != 0 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 3000) check_val("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check_val({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_val({tag, "_out_word"}, out_word, 32'd0);
        check_val({tag, "_out_sel"}, 32'(out_sel), 32'd0);
        check_val({tag, "_out_round"}, 32'(out_round), 32'd0);
        check_val({tag, "_out_first"}, 32'(out_first), 32'd0);
        check_val({tag, "_out_last_block"}, 32'(out_last_block), 32'd0);
        check_val({tag, "_msg_done"}, 32'(msg_done), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check_val("msg_done", 32'(msg_done), 32'(done_pending));
            done_pending = 1'b0;
            if (out_valid) begin
                check_val("in_ready_emit", 32'(in_ready), 32'd0);
                if (sb.size() == 0) begin
                    check_val("unexpected_round", 32'(out_round), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check_val("round", 32'(out_round), 32'(e.round));
                    check_val("word", out_word, e.word);
                    check_val("sel", 32'(out_sel), 32'(e.sel));
                    check_val("first", 32'(out_first), 32'(e.round == 6'd0));
                    check_val("last_block", 32'(out_last_block), 32'(e.last));
                    if (e.round == 6'd63 && e.last) done_pending = 1'b1;
                end
            end
        end
    end

    initial begin
        int c;
        rst        = 1'b1;
        in_data    = 32'h0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_bytes   = 2'd0;
        core_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_val("in_ready_pre", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_val("in_ready_post", 32'(in_ready), 32'd1);

        make_msg(3, 1'b1);  send_msg(); wait_drain();   // "abc"
        make_msg(55, 1'b0); send_msg(); wait_drain();
        make_msg(56, 1'b0); send_msg(); wait_drain();
        make_msg(64, 1'b0); send_msg(); wait_drain();
        make_msg(100, 1'b0); send_msg(); wait_drain();
        make_msg(62, 1'b0); send_msg(); wait_drain();

        // Stall in WAIT with ignored input traffic.
        core_ready = 1'b0;
        make_msg(8, 1'b0);
        send_msg();
        repeat (18) @(negedge clk);
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            check_val("wait_out_valid", 32'(out_valid), 32'd0);
            check_val("wait_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid   = 1'b0;
        in_last    = 1'b0;
        core_ready = 1'b1;
        @(negedge clk);
        check_val("emit_start_valid", 32'(out_valid), 32'd1);
        check_val("emit_start_first", 32'(out_first), 32'd1);
        wait_drain();

        // Reset in the middle of EMIT.
        make_msg(3, 1'b1);
        send_msg();
        c = 0;
        while (!(out_valid && out_round == 6'd30) && c < 500) begin
            @(negedge clk);
            c++;
        end
        if (c >= 500) check_val("reach_t30_timeout", 32'(c), 32'd0);
        #2 rst = 1'b1;
        #1 check_all_zero("mid_rst");
        sb.delete();
        done_pending = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("rst_hold");
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_val("rel_in_ready_pre", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_val("rel_in_ready_post", 32'(in_ready), 32'd1);
        make_msg(3, 1'b1); send_msg(); wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
